// File: rtl/lsr_deser.sv
// Serial-in, parallel-out deserializer: MSB-first bits are assembled into WIDTH-bit
// words and handed to a valid/ready consumer through a one-word holding register.
`timescale 1ns/1ps

module lsr_deser #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow,
  output logic [CW-1:0]    bit_cnt
);

  // state | meaning
  // EMPTY | holding register has no word for the consumer
  // FULL  | holding register presents out_data with out_valid=1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  hold_state_t state_q, state_d;

  // The assembly register's top bit would always be zero, so only WIDTH-1 bits are kept.
  logic [WIDTH-2:0] asm_q;
  logic [WIDTH-1:0] word;
  logic             take;
  logic             complete;
  logic             load;
  logic             drop;

  assign take      = sin_valid & ~clr;
  assign complete  = take & (bit_cnt == LAST);
  assign word      = {asm_q, sin_bit};
  assign out_valid = (state_q == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          // A completion in the drain cycle refills without a bubble.
          if (complete) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end else if (complete) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      asm_q   <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
      asm_q   <= '0;
    end else if (take) begin
      if (complete) begin
        bit_cnt <= '0;
        asm_q   <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
        asm_q   <= word[WIDTH-2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsr_deser.sv
// Self-checking bench for lsr_deser (WIDTH=4): directed scenarios plus a randomized
// run compared against a bit-queue reference model.
`timescale 1ns/1ps

module tb_lsr_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       overflow;
  logic [1:0] bit_cnt;

  int checks = 0;
  int failures = 0;

  lsr_deser #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .overflow(overflow), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; clr = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, overflow, bit_cnt} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: data=%b valid=%b ovf=%b cnt=%0d, want all 0",
               out_data, out_valid, overflow, bit_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b1011;
    logic [1:0] cnt_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1; sin_bit = bits[3-i];
      tick();
      checks++;
      if (bit_cnt !== cnt_exp[i]) begin
        failures++;
        $display("FAIL basic_cnt[%0d]: got %0d want %0d", i, bit_cnt, cnt_exp[i]);
      end
      checks++;
      if (out_valid !== (i == 3)) begin
        failures++;
        $display("FAIL basic_valid[%0d]: got %b want %b", i, out_valid, (i == 3));
      end
    end
    checks++;
    if (out_data !== 4'b1011) begin
      failures++;
      $display("FAIL basic_data: got %b want 1011", out_data);
    end
    sin_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'b1011) begin
      failures++;
      $display("FAIL basic_drain: valid=%b data=%b want 0/1011", out_valid, out_data);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] bits = 4'b0011;
    int words = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1; sin_bit = bits[3-i];
      tick();
      if (out_valid) begin
        words++;
        checks++;
        if (out_data !== 4'b0011) begin
          failures++;
          $display("FAIL gapped_data: got %b want 0011", out_data);
        end
      end
      sin_valid = 1'b0; sin_bit = ~sin_bit;
      for (int g = 0; g < 2; g++) begin
        tick();
        if (out_valid) words++;
        checks++;
        if (bit_cnt !== 2'((i + 1) % 4)) begin
          failures++;
          $display("FAIL gapped_cnt_hold[%0d]: got %0d want %0d", i, bit_cnt, (i + 1) % 4);
        end
      end
    end
    checks++;
    if (words != 1) begin
      failures++;
      $display("FAIL gapped_word_count: got %0d want 1", words);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bits = 8'b1010_0110;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin_valid = 1'b1; sin_bit = bits[7-i];
      tick();
      if (i >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1010) begin
          failures++;
          $display("FAIL ovf_stable[%0d]: valid=%b data=%b want 1/1010", i, out_valid, out_data);
        end
      end
      checks++;
      if (overflow !== (i == 7)) begin
        failures++;
        $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow, (i == 7));
      end
    end
    sin_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drain: valid=%b ovf=%b want 0/1", out_valid, overflow);
    end
    tick(); tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: got %b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits = 8'b1100_0101;
    int valids = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sin_valid = (i < 8); sin_bit = (i < 8) ? bits[7-i] : 1'b0;
      tick();
      if (out_valid) valids++;
      if (i == 3 || i == 7) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ((i == 3) ? 4'b1100 : 4'b0101)) begin
          failures++;
          $display("FAIL b2b_word[%0d]: valid=%b data=%b", i, out_valid, out_data);
        end
      end
    end
    checks++;
    if (valids != 2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_cycles: valids=%0d ovf=%b want 2/0", valids, overflow);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin_valid = 1'b1; sin_bit = bits[7-i];
      out_ready = (i == 7);
      tick();
      if (i >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== ((i == 7) ? 4'b0101 : 4'b1100) || overflow !== 1'b0) begin
          failures++;
          $display("FAIL b2b_nobubble[%0d]: valid=%b data=%b ovf=%b", i, out_valid, out_data, overflow);
        end
      end
    end
    sin_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_final_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_resync();
    logic [3:0] bits = 4'b0110;
    out_ready = 1'b1;
    sin_valid = 1'b1; sin_bit = 1'b1;
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bit_cnt !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL resync_clr: cnt=%0d valid=%b want 0/0", bit_cnt, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      sin_bit = bits[3-i];
      tick();
      if (i == 2) begin
        checks++;
        if (bit_cnt !== 2'd3 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL resync_cnt: cnt=%0d valid=%b want 3/0", bit_cnt, out_valid);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b0110) begin
      failures++;
      $display("FAIL resync_word: valid=%b data=%b want 1/0110", out_valid, out_data);
    end
    sin_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [3:0] bits = 4'b1001;
    out_ready = 1'b0;
    sin_valid = 1'b1; sin_bit = 1'b1;
    repeat (6) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1111 || bit_cnt !== 2'd2) begin
      failures++;
      $display("FAIL arst_setup: valid=%b data=%b cnt=%0d want 1/1111/2", out_valid, out_data, bit_cnt);
    end
    sin_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, overflow, bit_cnt} !== 8'h00) begin
      failures++;
      $display("FAIL arst_immediate: data=%b valid=%b ovf=%b cnt=%0d want all 0",
               out_data, out_valid, overflow, bit_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1; sin_bit = bits[3-i];
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1001) begin
      failures++;
      $display("FAIL arst_fresh_word: valid=%b data=%b want 1/1001", out_valid, out_data);
    end
    sin_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int         mbits[$];
    logic       m_valid = 1'b0;
    logic [3:0] m_data = 4'd0;
    logic       m_ovf = 1'b0;
    logic [3:0] w;
    logic       fresh;
    logic [1:0] m_cnt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      clr       = ($urandom_range(0, 15) == 0);
      sin_valid = ($urandom_range(0, 3) != 0);
      sin_bit   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      fresh = 1'b0;
      w = 4'd0;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (clr) begin
        mbits.delete();
        m_ovf = 1'b0;
      end else if (sin_valid) begin
        mbits.push_back(int'(sin_bit));
        if (mbits.size() == 4) begin
          foreach (mbits[k]) w = 4'(w * 2 + mbits[k]);
          fresh = 1'b1;
          mbits.delete();
        end
      end
      if (fresh) begin
        if (m_valid) m_ovf = 1'b1;
        else begin
          m_valid = 1'b1;
          m_data  = w;
        end
      end
      m_cnt = 2'(mbits.size());
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || overflow !== m_ovf || bit_cnt !== m_cnt) begin
        failures++;
        $display("FAIL random[%0d]: got v=%b d=%b o=%b c=%0d want v=%b d=%b o=%b c=%0d",
                 n, out_valid, out_data, overflow, bit_cnt, m_valid, m_data, m_ovf, m_cnt);
      end
    end
    clr = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_back_to_back();
    test_resync();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsr_deser.md
Name: lsr_deser

Overview:
- Serial-in, parallel-out deserializer: the receiving end for the team's 4-bit shift-register datapath.
- Accepts a bit stream MSB-first, shifts it left into an assembly register, and presents each completed WIDTH-bit word on a valid/ready output port.
- A one-word holding register decouples assembly from the consumer.
- A sticky overflow flag reports words lost to backpressure.

Parameters:
- WIDTH, 4, bits per word; must be >= 2.
- CW, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous frame resync: clears the bit counter, the assembly register and the overflow flag; does not touch the holding register.
- sin_valid  in  1  sin_bit is sampled on this cycle.
- sin_bit  in  1  serial data bit, MSB of each word first.
- out_ready  in  1  consumer accepts out_data this cycle when out_valid=1.
- out_data  out  WIDTH  completed word.
- out_valid  out  1  holding register full.
- overflow  out  1  sticky: a completed word was dropped.
- bit_cnt  out  CW  number of bits currently in the assembly register, 0..WIDTH-1.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately): out_data=0, out_valid=0, overflow=0, bit_cnt=0, assembly register=0. Reset asserted mid-word discards the partial word and any held word.

Assembly, on a cycle with sin_valid=1 and clr=0:
- asm <= {asm[WIDTH-2:0], sin_bit}.
- bit_cnt increments.
- When bit_cnt==WIDTH-1 the word completes: the complete word is {asm[WIDTH-2:0], sin_bit}, bit_cnt wraps to 0, and asm clears to 0.
- sin_valid=0 holds asm and bit_cnt. Gaps between bits are allowed.

Holding register, two states:
- EMPTY (out_valid=0):
  - Word completes -> load out_data, go FULL.
  - out_valid rises the cycle after the last bit is sampled; latency is 1 clock.
- FULL (out_valid=1):
  - out_ready=1 and no completion -> go EMPTY. out_data keeps its last value.
  - out_ready=1 and completion in the same cycle -> load the new word, stay FULL. No bubble, no overflow.
  - out_ready=0 and completion -> new word dropped, overflow <= 1, out_data unchanged.
  - out_ready=0 and no completion -> hold.

Output stability:
- out_data and out_valid never change while out_valid=1 and out_ready=0, except on reset.

clr:
- Has priority over sin_valid in the same cycle: the bit is discarded.
- Results: bit_cnt=0, asm=0, overflow=0.
- An out_ready handshake in the same cycle still completes normally.

Overflow:
- Once set, stays 1 until clr or rst.
- Further drops keep it at 1.

Other:
- out_ready while EMPTY has no effect.
- There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset/basic word (WIDTH=4): after rst release, send bits 1,0,1,1 with sin_valid=1 on consecutive cycles and out_ready=1 -> out_valid=1 one cycle after the 4th bit, out_data=4'b1011, bit_cnt sequence 1,2,3,0, then out_valid=0 the following cycle.
2. Gapped input: send bits 0,0,1,1 with sin_valid low for 2 cycles between each bit -> single word 4'b0011, bit_cnt holds during gaps, no extra words.
3. Backpressure and overflow: out_ready=0, stream 1010 then 0110 -> out_data=4'b1010 stays stable with out_valid=1, overflow=1 after the 8th bit. Then out_ready=1 -> out_valid drops, overflow stays 1 until a clr pulse clears it.
4. Back-to-back with simultaneous drain: out_ready=1 continuously, stream 1100 then 0101 with no gaps -> out_valid high for exactly one cycle per word, words 4'b1100 then 4'b0101, overflow stays 0. Repeat with out_ready=0 until the second word's last bit and out_ready=1 on that cycle -> out_data moves from 1100 to 0101 with no bubble and no overflow.
5. Resync: send bits 1,1, pulse clr together with sin_valid=1, then send 0,1,1,0 -> bit_cnt=0 after clr, and the word is 4'b0110; the bits sent before clr and the bit sent with clr are both discarded.
6. Async reset mid-operation: assert rst low between clock edges after 2 bits, with out_valid=1 holding 4'b1111 -> all outputs go to 0 immediately, without waiting for a clock edge. After release, a fresh 4-bit stream 1001 produces 4'b1001.
